// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared defaults and counter sizing for the input debouncer
package input_debouncer_pkg;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
   localparam int WIDTH_DEFAULT = 3;
   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronizer + stability counter + clean register; edge pulses built when INPUT_DEBOUNCER_EDGE_EN is defined
module debounce_channel
   import input_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o,
   output logic settled_o
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
   logic sync1_q, sync2_q, clean_q, clean_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // next state: count while the synchronized level differs, accept it at terminal count
   always_comb begin
      cnt_d   = !ena ? cnt_q : (sync2_q == clean_q || cnt_q == TERM) ? '0 : cnt_q + 1'b1;
      clean_d = (ena && sync2_q != clean_q && cnt_q == TERM) ? sync2_q : clean_q;
   end
   // synchronizer always runs; counter and clean level freeze when disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end
   // settled looks at the post-edge state so stable rises on the accepting edge itself
   assign settled_o = (clean_d == sync2_q) && (cnt_d == '0);
   assign clean_o = clean_q;
`ifdef INPUT_DEBOUNCER_EDGE_EN
   logic rise_q, fall_q;
   // one-cycle pulses in the cycle the new clean level appears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= ena & clean_d & ~clean_q;
         fall_q <= ena & ~clean_d & clean_q;
      end
   end
   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: WIDTH independent debounce channels plus an all-settled flag; edge pulses gated by INPUT_DEBOUNCER_EDGE_EN
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             stable_out
);
   logic [WIDTH-1:0] settled;
   logic stable_q;
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .ena       (ena),
         .raw_i     (raw_in[i]),
         .clean_o   (clean_out[i]),
         .rise_o    (rise_pulse[i]),
         .fall_o    (fall_pulse[i]),
         .settled_o (settled[i])
      );
   end
   // registered AND of all channels; held while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable_q <= 1'b1;
      else if (ena) stable_q <= &settled;
   end
   assign stable_out = stable_q;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed + random stimulus against a cycle-level reference model with a scoreboard queue
module tb_input_debouncer;
   localparam int W = 3;
   localparam int D = 16;
   logic clk = 1'b0;
   logic rst_n, ena;
   logic [W-1:0] raw_in, clean_out, rise_pulse, fall_pulse;
   logic stable_out;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic stable;
   } exp_t;
   exp_t q[$];
   input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .stable_out (stable_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference model: a level is accepted once the synchronized input has
   // disagreed with the accepted level on D consecutive enabled edges.
   logic [W-1:0] s1_m, s2_m, cl_m, nc;
   logic st_m;
   int run_m[W];
   exp_t e_m;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_m = '0;
         s2_m = '0;
         cl_m = '0;
         st_m = 1'b1;
         for (int i = 0; i < W; i++) run_m[i] = 0;
      end else begin
         nc = cl_m;
         if (ena) begin
            for (int i = 0; i < W; i++) begin
               if (s2_m[i] != cl_m[i]) begin
                  run_m[i] = run_m[i] + 1;
                  if (run_m[i] == D) begin
                     nc[i] = s2_m[i];
                     run_m[i] = 0;
                  end
               end else run_m[i] = 0;
            end
            st_m = (nc == s2_m);
         end
         e_m.clean = nc;
`ifdef INPUT_DEBOUNCER_EDGE_EN
         e_m.rise = nc & ~cl_m;
         e_m.fall = ~nc & cl_m;
`else
         e_m.rise = '0;
         e_m.fall = '0;
`endif
         e_m.stable = st_m;
         q.push_back(e_m);
         cl_m = nc;
         s2_m = s1_m;
         s1_m = raw_in;
      end
   end
   // monitor: every cycle out of reset the DUT presents a result to compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_clean", int'(clean_out), int'(e.clean));
            chk("sb_rise", int'(rise_pulse), int'(e.rise));
            chk("sb_fall", int'(fall_pulse), int'(e.fall));
            chk("sb_stable", int'(stable_out), int'(e.stable));
         end
      end
   end
   task automatic measure(input int ch, input logic lvl, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (clean_out[ch] !== lvl && n < 100);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int n;
      int hold[W];
      rst_n = 1'b0;
      ena = 1'b1;
      raw_in = '1;
      repeat (3) @(negedge clk);
      chk("rst_clean", int'(clean_out), 0);
      chk("rst_rise", int'(rise_pulse), 0);
      chk("rst_fall", int'(fall_pulse), 0);
      chk("rst_stable", int'(stable_out), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      chk("post_rst_stable", int'(stable_out), 1);
      @(negedge clk);
      raw_in = '0;
      repeat (40) @(negedge clk);
      raw_in[0] = 1'b1;
      measure(0, 1'b1, n);
      chk("press_edge", n - 1, D + 1);
`ifdef INPUT_DEBOUNCER_EDGE_EN
      chk("press_rise", int'(rise_pulse[0]), 1);
`else
      chk("press_rise", int'(rise_pulse[0]), 0);
`endif
      repeat (5) @(negedge clk);
      raw_in[0] = 1'b0;
      measure(0, 1'b0, n);
      chk("release_edge", n - 1, D + 1);
      repeat (5) @(negedge clk);
      raw_in[1] = 1'b1;
      repeat (10) @(negedge clk);
      raw_in[1] = 1'b0;
      repeat (30) @(negedge clk);
      chk("glitch_clean", int'(clean_out[1]), 0);
      chk("glitch_stable", int'(stable_out), 1);
      for (int k = 0; k < 4; k++) begin
         raw_in[2] = (k % 2 == 0);
         repeat (3) @(negedge clk);
      end
      raw_in[2] = 1'b1;
      measure(2, 1'b1, n);
      chk("bounce_edge", n - 1, D + 1);
      @(negedge clk);
      raw_in[2] = 1'b0;
      repeat (30) @(negedge clk);
      raw_in[0] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      ena = 1'b0;
      repeat (20) @(negedge clk);
      chk("ena_hold_clean", int'(clean_out[0]), 0);
      chk("ena_hold_stable", int'(stable_out), 0);
      ena = 1'b1;
      measure(0, 1'b1, n);
      chk("ena_resume_edges", n, 8);
      @(negedge clk);
      raw_in[0] = 1'b0;
      repeat (30) @(negedge clk);
      raw_in[0] = 1'b1;
      repeat (14) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_clean", int'(clean_out), 0);
      chk("async_rst_stable", int'(stable_out), 1);
      @(negedge clk);
      rst_n = 1'b1;
      measure(0, 1'b1, n);
      chk("restart_after_rst", n - 1, D + 1);
      @(negedge clk);
      for (int i = 0; i < W; i++) hold[i] = 1;
      repeat (1000) begin
         @(negedge clk);
         ena = ($urandom_range(0, 15) != 0);
         for (int i = 0; i < W; i++) begin
            hold[i]--;
            if (hold[i] == 0) begin
               raw_in[i] = ~raw_in[i];
               hold[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(16, 40);
            end
         end
      end
      ena = 1'b1;
      repeat (40) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
